// File: rtl/timekeeper_rtc.sv
// Real-time clock: prescaler-driven seconds/minutes/hours/days cascade with set-load and alarm match.
// Fields and event pulses are registered (one cycle after the causing edge); no backpressure.
module timekeeper_rtc #(
  parameter int unsigned CLK_DIV = 6,
  parameter int unsigned DAY_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             set_valid,
  input  logic [4:0]       set_hours,
  input  logic [5:0]       set_minutes,
  input  logic [5:0]       set_seconds,
  input  logic             alarm_en,
  input  logic [4:0]       alarm_hours,
  input  logic [5:0]       alarm_minutes,
  output logic [5:0]       seconds,
  output logic [5:0]       minutes,
  output logic [4:0]       hours,
  output logic [DAY_W-1:0] days,
  output logic             sec_tick,
  output logic             min_tick,
  output logic             hour_tick,
  output logic             day_tick,
  output logic             alarm_pulse,
  output logic             set_err
);

  localparam int unsigned     PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);

  logic [PS_W-1:0]  presc;
  logic             sec_evt;
  logic             set_ok;
  logic             sec_wrap;
  logic             min_wrap;
  logic             hour_wrap;
  logic             alarm_hit;
  logic [5:0]       sec_nxt;
  logic [5:0]       min_nxt;
  logic [4:0]       hour_nxt;
  logic [DAY_W-1:0] day_nxt;

  // Next-time values for a second event; the whole cascade resolves in one edge.
  always_comb begin
    sec_evt   = run && (presc == PS_LAST);
    set_ok    = (set_hours <= 5'd23) && (set_minutes <= 6'd59) && (set_seconds <= 6'd59);
    sec_wrap  = (seconds == 6'd59);
    min_wrap  = sec_wrap && (minutes == 6'd59);
    hour_wrap = min_wrap && (hours == 5'd23);
    sec_nxt   = sec_wrap ? 6'd0 : seconds + 6'd1;
    min_nxt   = minutes;
    if (sec_wrap) begin
      min_nxt = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
    end
    hour_nxt = hours;
    if (min_wrap) begin
      hour_nxt = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
    end
    day_nxt   = hour_wrap ? days + DAY_W'(1) : days;
    // Out-of-range targets can never equal a legal next time, but reject them explicitly.
    alarm_hit = alarm_en && (alarm_hours <= 5'd23) && (alarm_minutes <= 6'd59) &&
                (hour_nxt == alarm_hours) && (min_nxt == alarm_minutes) && (sec_nxt == 6'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      seconds     <= '0;
      minutes     <= '0;
      hours       <= '0;
      days        <= '0;
      sec_tick    <= 1'b0;
      min_tick    <= 1'b0;
      hour_tick   <= 1'b0;
      day_tick    <= 1'b0;
      alarm_pulse <= 1'b0;
      set_err     <= 1'b0;
    end else begin
      sec_tick    <= 1'b0;
      min_tick    <= 1'b0;
      hour_tick   <= 1'b0;
      day_tick    <= 1'b0;
      alarm_pulse <= 1'b0;
      set_err     <= 1'b0;
      // A set request consumes the cycle: any coincident second event is dropped.
      if (set_valid) begin
        if (set_ok) begin
          presc   <= '0;
          seconds <= set_seconds;
          minutes <= set_minutes;
          hours   <= set_hours;
        end else begin
          set_err <= 1'b1;
        end
      end else if (run) begin
        if (sec_evt) begin
          presc       <= '0;
          seconds     <= sec_nxt;
          minutes     <= min_nxt;
          hours       <= hour_nxt;
          days        <= day_nxt;
          sec_tick    <= 1'b1;
          min_tick    <= sec_wrap;
          hour_tick   <= min_wrap;
          day_tick    <= hour_wrap;
          alarm_pulse <= alarm_hit;
        end else begin
          presc <= presc + PS_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_timekeeper_rtc.sv
// Directed bench for timekeeper_rtc: a CLK_DIV=6 instance for timekeeping and a CLK_DIV=1, DAY_W=2 instance for day wrap.
module tb_timekeeper_rtc;

  logic       clk = 1'b0;
  logic       rst, run, set_valid, alarm_en;
  logic [4:0] set_hours, alarm_hours;
  logic [5:0] set_minutes, set_seconds, alarm_minutes;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic [15:0] days;
  logic       sec_tick, min_tick, hour_tick, day_tick, alarm_pulse, set_err;

  logic       b_rst, b_run, b_set_valid;
  logic [5:0] b_seconds, b_minutes;
  logic [4:0] b_hours;
  logic [1:0] b_days;
  logic       b_sec_tick, b_min_tick, b_hour_tick, b_day_tick, b_alarm_pulse, b_set_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  timekeeper_rtc #(.CLK_DIV(6), .DAY_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .set_valid(set_valid),
    .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
    .alarm_en(alarm_en), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .seconds(seconds), .minutes(minutes), .hours(hours), .days(days),
    .sec_tick(sec_tick), .min_tick(min_tick), .hour_tick(hour_tick), .day_tick(day_tick),
    .alarm_pulse(alarm_pulse), .set_err(set_err)
  );

  timekeeper_rtc #(.CLK_DIV(1), .DAY_W(2)) dut_b (
    .clk(clk), .rst(b_rst), .run(b_run), .set_valid(b_set_valid),
    .set_hours(5'd23), .set_minutes(6'd59), .set_seconds(6'd59),
    .alarm_en(1'b0), .alarm_hours(5'd0), .alarm_minutes(6'd0),
    .seconds(b_seconds), .minutes(b_minutes), .hours(b_hours), .days(b_days),
    .sec_tick(b_sec_tick), .min_tick(b_min_tick), .hour_tick(b_hour_tick), .day_tick(b_day_tick),
    .alarm_pulse(b_alarm_pulse), .set_err(b_set_err)
  );

  // Advance one edge, then settle so outputs reflect it and new inputs apply to the next edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_set(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_valid = 1'b1; set_hours = h; set_minutes = m; set_seconds = s;
    tick();
    set_valid = 1'b0;
  endtask

  task automatic test_reset();
    run = 1'b0;
    do_reset();
    n_total++; if ({hours, minutes, seconds} !== 17'd0) $display("FAIL reset_time got %0d:%0d:%0d exp 0:0:0", hours, minutes, seconds); else n_pass++;
    n_total++; if (days !== 16'd0) $display("FAIL reset_days got %0d exp 0", days); else n_pass++;
    n_total++; if ({sec_tick, min_tick, hour_tick, day_tick, alarm_pulse, set_err} !== 6'b0)
      $display("FAIL reset_pulses got %b exp 000000", {sec_tick, min_tick, hour_tick, day_tick, alarm_pulse, set_err}); else n_pass++;
  endtask

  task automatic test_first_second();
    run = 1'b1;
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) begin
        n_total++; if (sec_tick !== 1'b1 || seconds !== 6'd1) $display("FAIL first_second cyc%0d got tick=%b sec=%0d exp tick=1 sec=1", i, sec_tick, seconds); else n_pass++;
      end else begin
        n_total++; if (sec_tick !== 1'b0) $display("FAIL first_second_idle cyc%0d got tick=%b exp 0", i, sec_tick); else n_pass++;
      end
    end
  endtask

  task automatic test_rollover();
    run = 1'b1;
    do_reset();
    for (int d = 0; d < 5; d++) begin
      do_set(5'd23, 6'd59, 6'd59);
      tick(6);
    end
    n_total++; if (days !== 16'd5) $display("FAIL rollover_days5 got %0d exp 5", days); else n_pass++;
    do_set(5'd23, 6'd59, 6'd58);
    tick(6);
    n_total++; if (seconds !== 6'd59 || sec_tick !== 1'b1 || min_tick !== 1'b0)
      $display("FAIL rollover_step1 got sec=%0d st=%b mt=%b exp 59 1 0", seconds, sec_tick, min_tick); else n_pass++;
    tick(6);
    n_total++; if ({hours, minutes, seconds} !== 17'd0 || days !== 16'd6)
      $display("FAIL rollover_time got %0d:%0d:%0d d%0d exp 0:0:0 d6", hours, minutes, seconds, days); else n_pass++;
    n_total++; if ({sec_tick, min_tick, hour_tick, day_tick} !== 4'b1111)
      $display("FAIL rollover_ticks got %b exp 1111", {sec_tick, min_tick, hour_tick, day_tick}); else n_pass++;
    tick();
    n_total++; if ({sec_tick, min_tick, hour_tick, day_tick} !== 4'b0000)
      $display("FAIL rollover_ticks_after got %b exp 0000", {sec_tick, min_tick, hour_tick, day_tick}); else n_pass++;
  endtask

  task automatic test_set();
    run = 1'b1;
    do_set(5'd3, 6'd4, 6'd5);
    do_set(5'd10, 6'd60, 6'd0);
    n_total++; if (set_err !== 1'b1) $display("FAIL set_err_pulse got %b exp 1", set_err); else n_pass++;
    n_total++; if (hours !== 5'd3 || minutes !== 6'd4 || seconds !== 6'd5)
      $display("FAIL set_err_time got %0d:%0d:%0d exp 3:4:5", hours, minutes, seconds); else n_pass++;
    tick();
    n_total++; if (set_err !== 1'b0) $display("FAIL set_err_once got %b exp 0", set_err); else n_pass++;
    do_set(5'd1, 6'd1, 6'd1);
    tick(5);
    do_set(5'd10, 6'd20, 6'd30);
    n_total++; if (hours !== 5'd10 || minutes !== 6'd20 || seconds !== 6'd30 || sec_tick !== 1'b0)
      $display("FAIL set_vs_event got %0d:%0d:%0d st=%b exp 10:20:30 st=0", hours, minutes, seconds, sec_tick); else n_pass++;
    tick(6);
    n_total++; if (seconds !== 6'd31 || sec_tick !== 1'b1) $display("FAIL set_presc_clear got sec=%0d st=%b exp 31 1", seconds, sec_tick); else n_pass++;
  endtask

  task automatic test_alarm();
    run = 1'b1;
    alarm_hours = 5'd7; alarm_minutes = 6'd30;
    alarm_en = 1'b1;
    do_set(5'd7, 6'd29, 6'd59);
    tick(5);
    n_total++; if (alarm_pulse !== 1'b0) $display("FAIL alarm_early got %b exp 0", alarm_pulse); else n_pass++;
    tick();
    n_total++; if (alarm_pulse !== 1'b1 || hours !== 5'd7 || minutes !== 6'd30 || seconds !== 6'd0)
      $display("FAIL alarm_hit got ap=%b %0d:%0d:%0d exp 1 7:30:0", alarm_pulse, hours, minutes, seconds); else n_pass++;
    tick();
    n_total++; if (alarm_pulse !== 1'b0) $display("FAIL alarm_once got %b exp 0", alarm_pulse); else n_pass++;
    alarm_en = 1'b0;
    do_set(5'd7, 6'd29, 6'd59);
    tick(6);
    n_total++; if (alarm_pulse !== 1'b0 || minutes !== 6'd30) $display("FAIL alarm_disabled got ap=%b min=%0d exp 0 30", alarm_pulse, minutes); else n_pass++;
    alarm_en = 1'b1;
    do_set(5'd7, 6'd30, 6'd0);
    n_total++; if (alarm_pulse !== 1'b0) $display("FAIL alarm_on_set got %b exp 0", alarm_pulse); else n_pass++;
    alarm_hours = 5'd24; alarm_minutes = 6'd0;
    do_set(5'd23, 6'd59, 6'd59);
    tick(6);
    n_total++; if (alarm_pulse !== 1'b0) $display("FAIL alarm_bad_target got %b exp 0", alarm_pulse); else n_pass++;
    alarm_en = 1'b0;
  endtask

  task automatic test_pause();
    run = 1'b1;
    do_set(5'd1, 6'd2, 6'd3);
    tick(3);
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sec_tick !== 1'b0 || seconds !== 6'd3) begin
        n_total++; $display("FAIL pause_frozen cyc%0d got sec=%0d st=%b exp 3 0", i, seconds, sec_tick);
      end
    end
    n_total++; if (seconds !== 6'd3 || minutes !== 6'd2 || hours !== 5'd1) $display("FAIL pause_hold got %0d:%0d:%0d exp 1:2:3", hours, minutes, seconds); else n_pass++;
    run = 1'b1;
    tick(2);
    n_total++; if (sec_tick !== 1'b0 || seconds !== 6'd3) $display("FAIL pause_resume_early got sec=%0d st=%b exp 3 0", seconds, sec_tick); else n_pass++;
    tick();
    n_total++; if (sec_tick !== 1'b1 || seconds !== 6'd4) $display("FAIL pause_resume got sec=%0d st=%b exp 4 1", seconds, sec_tick); else n_pass++;
  endtask

  task automatic test_rst_mid();
    run = 1'b1;
    do_set(5'd12, 6'd34, 6'd56);
    tick(5);
    rst = 1'b1;
    set_valid = 1'b1; set_hours = 5'd1; set_minutes = 6'd1; set_seconds = 6'd1;
    tick();
    rst = 1'b0; set_valid = 1'b0;
    n_total++; if ({hours, minutes, seconds} !== 17'd0 || days !== 16'd0)
      $display("FAIL rst_mid_time got %0d:%0d:%0d d%0d exp 0:0:0 d0", hours, minutes, seconds, days); else n_pass++;
    n_total++; if ({sec_tick, min_tick, hour_tick, day_tick, alarm_pulse, set_err} !== 6'b0)
      $display("FAIL rst_mid_pulses got %b exp 000000", {sec_tick, min_tick, hour_tick, day_tick, alarm_pulse, set_err}); else n_pass++;
  endtask

  task automatic test_day_wrap();
    b_run = 1'b1;
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      b_set_valid = 1'b1;
      tick();
      b_set_valid = 1'b0;
      tick();
      n_total++; if (b_days !== 2'(d) || b_day_tick !== 1'b1) $display("FAIL day_wrap_%0d got d=%0d dt=%b exp %0d 1", d, b_days, b_day_tick, d % 4); else n_pass++;
    end
    tick();
    n_total++; if (b_seconds !== 6'd1 || b_sec_tick !== 1'b1) $display("FAIL div1_sec1 got sec=%0d st=%b exp 1 1", b_seconds, b_sec_tick); else n_pass++;
    tick();
    n_total++; if (b_seconds !== 6'd2 || b_sec_tick !== 1'b1) $display("FAIL div1_sec2 got sec=%0d st=%b exp 2 1", b_seconds, b_sec_tick); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; run = 1'b0; set_valid = 1'b0; alarm_en = 1'b0;
    set_hours = '0; set_minutes = '0; set_seconds = '0;
    alarm_hours = '0; alarm_minutes = '0;
    b_rst = 1'b1; b_run = 1'b0; b_set_valid = 1'b0;
    #1;
    test_reset();
    test_first_second();
    test_rollover();
    test_set();
    test_alarm();
    test_pause();
    test_rst_mid();
    test_day_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timekeeper_rtc.md
TIMEKEEPER_RTC -- requirements
Module: timekeeper_rtc

Interface
REQ-001 SHALL have parameter CLK_DIV, default 6, meaning clk cycles per second (legal range 1 to 2^28).
REQ-002 SHALL have parameter DAY_W, default 16, meaning width of the day counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port run  input  1  1 = timekeeping advances; 0 = prescaler and time frozen.
REQ-006 SHALL have port set_valid  input  1  one-cycle request to load set_hours/set_minutes/set_seconds.
REQ-007 SHALL have ports set_hours  input  5, set_minutes  input  6, set_seconds  input  6  time to load.
REQ-008 SHALL have ports alarm_en  input  1, alarm_hours  input  5, alarm_minutes  input  6  alarm enable and target.
REQ-009 SHALL have ports seconds  output  6, minutes  output  6, hours  output  5, days  output  DAY_W  current time, all registered.
REQ-010 SHALL have ports sec_tick, min_tick, hour_tick, day_tick  output  1  one-cycle pulses on each field rollover.
REQ-011 SHALL have ports alarm_pulse  output  1 and set_err  output  1  one-cycle event pulses.

Function
REQ-012 SHALL run a prescaler counting 0..CLK_DIV-1 while run=1; a second event occurs in a cycle where run=1 and prescaler=CLK_DIV-1, and the prescaler then returns to 0.
REQ-013 SHALL, with CLK_DIV=1, produce a second event every cycle run=1.
REQ-014 SHALL, on a second event, increment seconds; 59 wraps to 0 and increments minutes in the same edge.
REQ-015 SHALL wrap minutes 59->0 and increment hours in the same edge; hours 23->0 and increment days in the same edge; days 2^DAY_W-1 wraps to 0.
REQ-016 SHALL keep the full cascade fully synchronous: all fields update on one clk edge, never on a derived edge or level.
REQ-017 SHALL assert sec_tick in the cycle after each second event (aligned with the updated seconds); min_tick/hour_tick/day_tick likewise, only when that field changed.
REQ-018 SHALL, when run=0, hold prescaler, all time fields, and deassert all tick outputs.
REQ-019 SHALL accept set_valid when set_hours<=23, set_minutes<=59, set_seconds<=59: load the three fields, clear the prescaler to 0, leave days unchanged; new values visible next cycle.
REQ-020 SHALL, for an out-of-range set request, leave all state unchanged and pulse set_err for one cycle in the next cycle.
REQ-021 SHALL give set_valid priority over a simultaneous second event: the event is discarded, no ticks pulse that cycle.
REQ-022 SHALL accept set_valid regardless of run.
REQ-023 SHALL pulse alarm_pulse for one cycle, aligned with the updated time, when alarm_en=1 and a second event yields hours=alarm_hours, minutes=alarm_minutes, seconds=0.
REQ-024 SHALL NOT pulse alarm_pulse as a result of a set load, even if the loaded time matches.
REQ-025 SHALL treat out-of-range alarm targets as never matching.

Reset
REQ-026 SHALL, with rst=1 at a clk edge, clear prescaler, seconds, minutes, hours, days to 0 and deassert all tick, alarm_pulse and set_err outputs.
REQ-027 SHALL give rst priority over set_valid and second events, including mid-cascade or mid-set.
REQ-028 SHALL start counting from prescaler=0 on the first cycle after rst deasserts with run=1.

Verification
REQ-029 SHALL cover: CLK_DIV=6, rst then run=1 -> seconds=1 and sec_tick=1 exactly 6 cycles after reset release; otherwise sec_tick=0.
REQ-030 SHALL cover: set 23:59:58, days=5, run=1 -> after 2 second events time 00:00:00, days=6, all four ticks pulse together in one cycle.
REQ-031 SHALL cover: set_valid with set_minutes=60 -> set_err=1 for one cycle, time unchanged; set_valid on the same cycle as a second event -> loaded value wins, no sec_tick.
REQ-032 SHALL cover: alarm_en=1, alarm 07:30, set 07:29:59 -> alarm_pulse=1 for one cycle with time 07:30:00; repeat with alarm_en=0 -> no pulse; set 07:30:00 directly -> no pulse.
REQ-033 SHALL cover: run=0 for 20 cycles mid-second -> fields and prescaler frozen, second event lands after remaining prescaler count on resume.
REQ-034 SHALL cover: rst asserted at 12:34:56 during a second event -> all outputs 0 next cycle; DAY_W=2 wrap: days 3 -> 0 on day rollover.
